// File: rtl/hazard_pkg.sv
// Shared constants for the forwarding/hazard controller: forward-select codes
// and FSM state encodings.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: matches one ID source register against the EX and MEM
// destinations and produces hit flags, load-use flag and the next forward select.
module fwd_src_cmp
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          id_valid,
  input  logic          rs_used,
  input  logic [AW-1:0] rs_addr,
  input  logic          ex_valid,
  input  logic          ex_reg_write,
  input  logic          ex_is_load,
  input  logic [AW-1:0] ex_rd_addr,
  input  logic          mem_valid,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] mem_rd_addr,
  output logic          ex_hit,
  output logic          mem_hit,
  output logic          load_use,
  output logic [1:0]    next_sel
);

  logic src_live;

  // Valid bits gate the address compare so X addresses cannot leak through.
  assign src_live = id_valid & rs_used;
  assign ex_hit   = src_live & ex_valid & ex_reg_write &
                    (ex_rd_addr == rs_addr) & (ex_rd_addr != '0);
  assign mem_hit  = src_live & mem_valid & mem_reg_write &
                    (mem_rd_addr == rs_addr) & (mem_rd_addr != '0);
  assign load_use = ex_hit & ex_is_load;

  always_comb begin
    next_sel = FWD_RF;
    if (ex_hit && !ex_is_load) next_sel = FWD_MEM;
    else if (mem_hit)          next_sel = FWD_WB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select register and load-use stall FSM for the 5-stage pipeline.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]    id_rs_used,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_is_load,
  input  logic [AW-1:0]         ex_rd_addr,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic [AW-1:0]         mem_rd_addr,
  input  logic                  mem_ready,
  output logic [NUM_SRC*2-1:0]  fwd_sel,
  output logic                  stall_if_id,
  output logic                  bubble_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  logic [NUM_SRC-1:0]   ex_hit_v;
  logic [NUM_SRC-1:0]   mem_hit_v;
  logic [NUM_SRC-1:0]   load_use_v;
  logic [NUM_SRC*2-1:0] next_sel_v;
  logic                 load_use_any;
  logic                 hits_unused;
  logic [0:0]           state, state_nxt;
  logic                 stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_cmp #(.AW(AW)) u_cmp (
      .id_valid      (id_valid),
      .rs_used       (id_rs_used[i]),
      .rs_addr       (id_rs_addr[i*AW +: AW]),
      .ex_valid      (ex_valid),
      .ex_reg_write  (ex_reg_write),
      .ex_is_load    (ex_is_load),
      .ex_rd_addr    (ex_rd_addr),
      .mem_valid     (mem_valid),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .ex_hit        (ex_hit_v[i]),
      .mem_hit       (mem_hit_v[i]),
      .load_use      (load_use_v[i]),
      .next_sel      (next_sel_v[2*i +: 2])
    );
  end

  assign load_use_any = |load_use_v;
  assign hits_unused  = ^{ex_hit_v, mem_hit_v};

  // LOAD_WAIT holds while memory is slow, and re-arms if the next ID
  // instruction also depends on a load sitting in EX.
  always_comb begin
    stall     = 1'b0;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (load_use_any) begin
          stall     = 1'b1;
          state_nxt = ST_LOAD_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (!mem_ready || load_use_any) stall = 1'b1;
        else                            state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign stall_if_id = reset_n & stall;
  assign bubble_ex   = reset_n & stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      fwd_sel <= '0;
    end else begin
      state   <= state_nxt;
      fwd_sel <= stall ? '0 : next_sel_v;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stall FSM, reset.
module tb_fwd_hazard_ctrl;
  localparam int AW = 5, NUM_SRC = 2, CNT_W = 32;

  logic clk = 1'b0, reset_n;
  logic id_valid, ex_valid, ex_reg_write, ex_is_load;
  logic mem_valid, mem_reg_write, mem_ready;
  logic [NUM_SRC*AW-1:0] id_rs_addr;
  logic [NUM_SRC-1:0]    id_rs_used;
  logic [AW-1:0]         ex_rd_addr, mem_rd_addr;
  logic [NUM_SRC*2-1:0]  fwd_sel;
  logic                  stall_if_id, bubble_ex;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.AW(AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_ready(mem_ready),
    .fwd_sel(fwd_sel), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic clr();
    id_valid = 0; id_rs_addr = '0; id_rs_used = '0;
    ex_valid = 0; ex_reg_write = 0; ex_is_load = 0; ex_rd_addr = '0;
    mem_valid = 0; mem_reg_write = 0; mem_rd_addr = '0; mem_ready = 1;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] used);
    id_valid = 1; id_rs_addr = {rs2, rs1}; id_rs_used = used;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic ld);
    ex_valid = 1; ex_reg_write = 1; ex_is_load = ld; ex_rd_addr = rd;
  endtask

  task automatic set_mem(input logic [4:0] rd);
    mem_valid = 1; mem_reg_write = 1; mem_rd_addr = rd;
  endtask

  task automatic test_reset();
    clr(); reset_n = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL reset_fwd got %b exp 0000", fwd_sel); end
    n_cmp++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b%b exp 00", stall_if_id, bubble_ex); end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
`endif
    reset_n = 1;
  endtask

  task automatic test_alu_chain();
    @(negedge clk); clr(); set_ex(5'd5, 0); set_id(5'd5, 5'd1, 2'b01);
    #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL alu_stall got %b exp 0", stall_if_id); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0001) begin n_bad++; $display("FAIL alu_fwd got %b exp 0001", fwd_sel); end
  endtask

  task automatic test_dist2();
    @(negedge clk); clr(); set_mem(5'd7); set_ex(5'd9, 0); set_id(5'd1, 5'd7, 2'b11);
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b1000) begin n_bad++; $display("FAIL dist2_fwd got %b exp 1000", fwd_sel); end
  endtask

  task automatic test_ex_wins();
    @(negedge clk); clr(); set_mem(5'd3); set_ex(5'd3, 0); set_id(5'd3, 5'd3, 2'b11);
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0101) begin n_bad++; $display("FAIL exwins_fwd got %b exp 0101", fwd_sel); end
    // rs2 not used: only rs1 forwards
    @(negedge clk); id_rs_used = 2'b01;
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0001) begin n_bad++; $display("FAIL unused_src got %b exp 0001", fwd_sel); end
  endtask

  task automatic test_x0();
    @(negedge clk); clr(); set_ex(5'd0, 0); set_mem(5'd0); set_id(5'd0, 5'd0, 2'b11);
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL x0_fwd got %b exp 0000", fwd_sel); end
    @(negedge clk); ex_is_load = 1; #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall got %b exp 0", stall_if_id); end
    // load-use pattern but no valid ID instruction, addresses X
    @(negedge clk); clr(); set_ex(5'd4, 1); id_rs_addr = 'x; id_rs_used = 2'b11; #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL idinv_stall got %b exp 0", stall_if_id); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL idinv_fwd got %b exp 0000", fwd_sel); end
  endtask

  task automatic test_load_use();
    int stalls;
    stalls = 0;
    // cycle 0: lw x4 in EX, ID reads x4 on both sources
    @(negedge clk); clr(); set_ex(5'd4, 1); set_id(5'd4, 5'd4, 2'b11); #1;
    n_cmp++; if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin n_bad++; $display("FAIL lu_c0 got %b%b exp 11", stall_if_id, bubble_ex); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL lu_c0_fwd got %b exp 0000", fwd_sel); end
    // load now in MEM, bubble in EX, memory busy for 2 cycles
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); clr(); set_mem(5'd4); set_id(5'd4, 5'd4, 2'b11); mem_ready = 0; #1;
      n_cmp++; if (stall_if_id !== 1'b1 || bubble_ex !== 1'b1) begin n_bad++; $display("FAIL lu_wait%0d got %b%b exp 11", c, stall_if_id, bubble_ex); end
    end
    @(negedge clk); mem_ready = 1; #1;
    n_cmp++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin n_bad++; $display("FAIL lu_release got %b%b exp 00", stall_if_id, bubble_ex); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b1010) begin n_bad++; $display("FAIL lu_fwd got %b exp 1010", fwd_sel); end
`ifdef HAZARD_PERF_CNT_EN
    n_cmp++; if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL lu_cnt got %0d exp 3", stall_cnt); end
`endif
    // back in IDLE: a slow memory with no load-use must not stall
    @(negedge clk); clr(); mem_ready = 0; set_mem(5'd4); set_id(5'd4, 5'd0, 2'b01); #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu_idle got %b exp 0", stall_if_id); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b0010) begin n_bad++; $display("FAIL lu_idle_fwd got %b exp 0010", fwd_sel); end
    stalls = stalls + 1;
  endtask

  task automatic test_one_cycle_load();
    // mem_ready on the first LOAD_WAIT cycle: exactly one stall cycle
    @(negedge clk); clr(); set_ex(5'd6, 1); set_id(5'd2, 5'd6, 2'b11); #1;
    n_cmp++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL lu1_c0 got %b exp 1", stall_if_id); end
    @(negedge clk); clr(); set_mem(5'd6); set_id(5'd2, 5'd6, 2'b11); mem_ready = 1; #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL lu1_c1 got %b exp 0", stall_if_id); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b1000) begin n_bad++; $display("FAIL lu1_fwd got %b exp 1000", fwd_sel); end
  endtask

  task automatic test_reset_mid_stall();
    // async clear of a nonzero fwd_sel
    @(negedge clk); clr(); set_ex(5'd5, 0); set_id(5'd5, 5'd0, 2'b01);
    @(posedge clk); #2; reset_n = 0; #1;
    n_cmp++; if (fwd_sel !== 4'b0000) begin n_bad++; $display("FAIL rst_async_fwd got %b exp 0000", fwd_sel); end
    @(negedge clk); reset_n = 1;
    // enter LOAD_WAIT with memory busy, then reset mid-cycle
    @(negedge clk); clr(); set_ex(5'd8, 1); set_id(5'd8, 5'd0, 2'b01);
    @(negedge clk); clr(); set_mem(5'd8); set_id(5'd8, 5'd0, 2'b01); mem_ready = 0; #1;
    n_cmp++; if (stall_if_id !== 1'b1) begin n_bad++; $display("FAIL rst_pre got %b exp 1", stall_if_id); end
    #2; reset_n = 0; #1;
    n_cmp++; if (stall_if_id !== 1'b0 || bubble_ex !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stall got %b%b exp 00", stall_if_id, bubble_ex); end
    @(negedge clk); reset_n = 1; #1;
    n_cmp++; if (stall_if_id !== 1'b0) begin n_bad++; $display("FAIL rst_idle got %b exp 0", stall_if_id); end
    @(posedge clk); #1;
    n_cmp++; if (fwd_sel !== 4'b1000 - 4'b1000 + 4'b0010) begin n_bad++; $display("FAIL rst_after_fwd got %b exp 0010", fwd_sel); end
  endtask

  initial begin
    clr(); reset_n = 1;
    test_reset();
    test_alu_chain();
    test_dist2();
    test_ex_wins();
    test_x0();
    test_load_use();
    test_one_cycle_load();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
